// File: rtl/mux_scan_if.sv
// Channel bus for mux_scan.
// master drives the channel data and the select controls; slave (the mux)
// returns the registered output and its status.
//   x       : N*W channel data, channel k at x[k*W +: W]
//   s       : manual channel select
//   mode    : 0 = manual, 1 = auto-scan
//   hold    : freezes scanning (scan mode only)
//   f       : registered selected channel data
//   cur_sel : channel currently driving f
//   sel_err : manual select is out of range
//   tick    : one-cycle pulse on each scan advance
interface mux_scan_if #(
  parameter int N = 7,
  parameter int W = 1
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] x;
  logic [SW-1:0]  s;
  logic           mode;
  logic           hold;
  logic [W-1:0]   f;
  logic [SW-1:0]  cur_sel;
  logic           sel_err;
  logic           tick;

  modport master (
    output x, s, mode, hold,
    input  f, cur_sel, sel_err, tick
  );

  modport slave (
    input  x, s, mode, hold,
    output f, cur_sel, sel_err, tick
  );
endinterface

// File: rtl/mux_scan.sv
// N-channel, W-bit registered multiplexer with manual select and an
// auto-scan mode that steps through the channels once every DIV clocks.
//   CLOCK_50 : system clock, rising edge
//   reset    : asynchronous, active-high
//   bus      : mux_scan_if slave (x, s, mode, hold in; f, cur_sel,
//              sel_err, tick out)
// All outputs are registered; f and cur_sel always describe the same channel.
module mux_scan #(
  parameter int N   = 7,
  parameter int W   = 1,
  parameter int DIV = 50000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  mux_scan_if.slave   bus
);
  localparam int SW = $clog2(N);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PS_LAST  = PW'(DIV - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(N - 1);

  logic [PW-1:0] ps_q, ps_next;
  logic [SW-1:0] sel_q, sel_next, sel_base;
  logic [W-1:0]  f_q, f_next;
  logic          err_q, err_next;
  logic          tick_q, adv;

  always_comb begin
    ps_next  = '0;
    adv      = 1'b0;
    sel_next = bus.s;
    // An out-of-range channel left over from manual mode is replaced by
    // channel 0 as soon as scanning starts.
    sel_base = (sel_q > SEL_LAST) ? '0 : sel_q;
    if (bus.mode) begin
      sel_next = sel_base;
      ps_next  = ps_q;
      if (!bus.hold) begin
        if (ps_q == PS_LAST) begin
          ps_next  = '0;
          adv      = 1'b1;
          sel_next = (sel_base == SEL_LAST) ? '0 : sel_base + SW'(1);
        end else begin
          ps_next = ps_q + PW'(1);
        end
      end
    end
  end

  // Explicit decode keeps out-of-range selects from indexing past x.
  always_comb begin
    f_next = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_next == SW'(k)) f_next = bus.x[k*W +: W];
    end
  end

  assign err_next = (sel_next > SEL_LAST);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ps_q   <= '0;
      sel_q  <= '0;
      f_q    <= '0;
      err_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      ps_q   <= ps_next;
      sel_q  <= sel_next;
      f_q    <= f_next;
      err_q  <= err_next;
      tick_q <= adv;
    end
  end

  assign bus.f       = f_q;
  assign bus.cur_sel = sel_q;
  assign bus.sel_err = err_q;
  assign bus.tick    = tick_q;
endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Parametrised N-channel, W-bit-wide registered multiplexer.
- Successor to the board-level switch-select mux: adds a registered output, an auto-scan mode that steps through the channels at a programmable rate, and out-of-range select detection.
- Sits between board inputs (SW/KEY or upstream logic) and LEDR/HEX display drivers inside the lab top level.

Parameters:
- N, 7, number of input channels (2..16).
- W, 1, width of each channel in bits (1..8).
- DIV, 50000000, scan prescale: in scan mode the channel advances once every DIV clocks (1 Hz at CLOCK_50). Must be 2 or more.
- SW, $clog2(N), select width (localparam, derived).

Ports:
- CLOCK_50 input 1 system clock, rising edge.
- reset input 1 asynchronous, active-high reset.
- x input N*W channel data; channel k occupies x[k*W +: W].
- s input SW manual channel select.
- mode input 1: 0 = manual, 1 = auto-scan.
- hold input 1: in scan mode, freezes the prescaler and the channel. Ignored in manual mode.
- f output W registered selected channel data.
- cur_sel output SW channel currently driving f.
- sel_err output 1 high while the applied manual select is at or above N.
- tick output 1 one-cycle pulse on each scan advance.

Behaviour:
- Reset (asynchronous, immediate): f=0, cur_sel=0, sel_err=0, tick=0, prescaler=0. This holds for reset asserted mid-scan; after release, scanning resumes from channel 0.
- Every output is registered. Each rising edge computes sel_next and updates:
  - cur_sel <= sel_next
  - f <= x[sel_next] if sel_next < N, otherwise 0
  - sel_err <= (sel_next >= N)
  - f and cur_sel therefore always describe the same channel.
- Manual mode (mode=0):
  - sel_next = s, so there is 1 cycle of latency from s/x to f.
  - x changes propagate to f one edge later even when s is static.
  - Prescaler is held at 0 and tick=0.
- Scan mode (mode=1, hold=0):
  - Prescaler counts 0..DIV-1.
  - On the edge where the prescaler equals DIV-1, it returns to 0, tick <= 1 for one cycle, and sel_next = cur_sel+1, wrapping N-1 -> 0.
  - On all other edges, sel_next = cur_sel and tick <= 0.
  - f still tracks live x of the current channel every cycle.
  - sel_err is always 0 in scan mode.
- Scan mode, hold=1:
  - Prescaler and cur_sel are frozen; tick=0.
  - f still tracks x[cur_sel].
  - On release of hold, counting continues from the frozen prescaler value.
- Mode transitions:
  - Manual->scan: the prescaler starts at 0. Scan begins from the current cur_sel; if cur_sel >= N, it forces channel 0 on the first scan edge. The first tick comes DIV edges after mode goes high.
  - Scan->manual: on the first manual edge cur_sel = s and the prescaler clears to 0.
- Simultaneous events: hold=1 on the same edge the prescaler reaches DIV-1 suppresses the advance and the tick.
- Widths: the prescaler is $clog2(DIV) bits. No arithmetic overflow is permitted; the wrap is explicit at N-1. No combinational path from any input to any output.

Test Plan:
- Reset and manual select (N=7, W=1, x=7'b1010010): apply reset. Then s=1 -> after 1 edge f=1, cur_sel=1, sel_err=0. Then s=0 -> f=0. Then s=6 -> f=1.
- Out-of-range select: N=7, s=3'b111 -> next edge f=0, sel_err=1. Then s=4 -> sel_err=0, f=x[4].
- Scan wrap (DIV=4, mode=1, from cur_sel=5):
  - tick pulses every 4 edges.
  - cur_sel sequence is 5,6,0,1.
  - f equals x[cur_sel] each cycle.
- Hold collision (DIV=4): assert hold on the edge the prescaler reaches 3 -> no tick, cur_sel unchanged. Release hold -> tick on the next edge, cur_sel+1.
- Reset mid-scan (DIV=4, W=4, cur_sel=3, prescaler=2): pulse reset between edges. Outputs go to 0 immediately, without waiting for a clock edge. After release, the first tick arrives 4 edges later and cur_sel=1.
- Mode switch (DIV=4): scan->manual with s=2 -> next edge cur_sel=2, tick=0. Manual->scan -> first tick exactly 4 edges after mode rises, cur_sel=3.
